// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared constants and rounding helper for the int32 -> int8 requantizer
package requant_pkg;

   localparam logic [2:0] CFG_SEL_BIAS    = 3'd0;
   localparam logic [2:0] CFG_SEL_MULT    = 3'd1;
   localparam logic [2:0] CFG_SEL_SHIFT   = 3'd2;
   localparam logic [2:0] CFG_SEL_OFFSET  = 3'd3;
   localparam logic [2:0] CFG_SEL_ACT_MIN = 3'd4;
   localparam logic [2:0] CFG_SEL_ACT_MAX = 3'd5;

   localparam logic signed [7:0]  INT8_MIN  = -8'sd128;
   localparam logic signed [7:0]  INT8_MAX  = 8'sd127;
   localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;
   localparam logic signed [31:0] INT32_MAX = 32'sh7fff_ffff;

   localparam logic signed [31:0] DEF_ACT_MIN = -32'sd128;
   localparam logic signed [31:0] DEF_ACT_MAX = 32'sd127;

   // Rounding nudges for the doubling high multiply: +2^30 and 1-2^30.
   localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
   localparam logic signed [63:0] NUDGE_NEG = 64'shffff_ffff_c000_0001;

   // Divide by 2^e rounding half away from zero.
   function automatic logic signed [31:0] rounding_divide_by_pot(
      input logic signed [31:0] x,
      input logic        [4:0]  e
   );
      logic        [31:0] mask;
      logic        [31:0] rem;
      logic        [31:0] thr;
      logic signed [31:0] q;
      mask = (32'd1 << e) - 32'd1;
      rem  = x & mask;
      thr  = (mask >> 1) + {31'd0, x[31]};
      q    = x >>> e;
      return q + ((rem > thr) ? 32'sd1 : 32'sd0);
   endfunction

endpackage

// File: rtl/requant_tables.sv
// rtl/requant_tables.sv - per-channel bias / multiplier / shift RAMs, read-before-write
module requant_tables
   import requant_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [2:0]    sel,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] bias,
   output logic [DW-1:0] mult,
   output logic [DW-1:0] shift
);

   logic [DW-1:0] bias_mem  [DEPTH];
   logic [DW-1:0] mult_mem  [DEPTH];
   logic [DW-1:0] shift_mem [DEPTH];

   // No reset: contents survive reset_n, and a same-cycle read sees the old word.
   always_ff @(posedge clk) begin
      if (we && sel == CFG_SEL_BIAS)  bias_mem[wr_addr]  <= wr_data;
      if (we && sel == CFG_SEL_MULT)  mult_mem[wr_addr]  <= wr_data;
      if (we && sel == CFG_SEL_SHIFT) shift_mem[wr_addr] <= wr_data;
      if (rd_en) begin
         bias  <= bias_mem[rd_addr];
         mult  <= mult_mem[rd_addr];
         shift <= shift_mem[rd_addr];
      end
   end

endmodule

// File: rtl/requant_stage.sv
// rtl/requant_stage.sv - 5-register pipeline: bias, TFLite per-channel requant, offset, clamp to int8
module requant_stage
   import requant_pkg::*;
#(
   parameter int BYTE_SIZE           = 8,
   parameter int INT32_SIZE          = 32,
   parameter int MAX_OUTPUT_CHANNELS = 128,
   parameter int CH_W                = $clog2(MAX_OUTPUT_CHANNELS)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  acc_valid,
   output logic                  acc_ready,
   input  logic [INT32_SIZE-1:0] acc_data,
   input  logic [CH_W-1:0]       acc_channel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BYTE_SIZE-1:0]  out_data,
   input  logic                  cfg_we,
   input  logic [2:0]            cfg_sel,
   input  logic [CH_W-1:0]       cfg_addr,
   input  logic [INT32_SIZE-1:0] cfg_data,
   output logic                  busy
);

   logic stall, advance;
   logic v0, v1, v2, v3, v4;

   logic [INT32_SIZE-1:0] bias_t, mult_t, shift_t;

   logic signed [INT32_SIZE-1:0] out_offset, act_min, act_max;

   logic signed [31:0] acc0;
   logic signed [31:0] sum1, x1_d;
   logic signed [31:0] x1, mult1, shift1;
   logic signed [63:0] ab, nudge, sum2_d, sum2;
   logic               sat2_d, sat2;
   logic signed [31:0] shift2;
   logic signed [63:0] biased, q64;
   logic signed [31:0] hm;
   logic        [31:0] neg_shift;
   logic        [4:0]  e3;
   logic signed [31:0] r3_d, r3;
   logic signed [32:0] y, lo, hi, y_lo, y_clamped;
   logic               unused_bits;

   assign stall     = v4 & ~out_ready;
   assign advance   = ~stall;
   assign acc_ready = advance;
   assign out_valid = v4;
   assign busy      = v0 | v1 | v2 | v3 | v4;

   requant_tables #(
      .DEPTH (MAX_OUTPUT_CHANNELS),
      .AW    (CH_W),
      .DW    (INT32_SIZE)
   ) u_tables (
      .clk     (clk),
      .we      (cfg_we),
      .sel     (cfg_sel),
      .wr_addr (cfg_addr),
      .wr_data (cfg_data),
      .rd_en   (advance),
      .rd_addr (acc_channel),
      .bias    (bias_t),
      .mult    (mult_t),
      .shift   (shift_t)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_offset <= '0;
         act_min    <= DEF_ACT_MIN;
         act_max    <= DEF_ACT_MAX;
      end else if (cfg_we) begin
         case (cfg_sel)
            CFG_SEL_OFFSET:  out_offset <= cfg_data;
            CFG_SEL_ACT_MIN: act_min    <= cfg_data;
            CFG_SEL_ACT_MAX: act_max    <= cfg_data;
            default: ;
         endcase
      end
   end

   // R1: bias add, optional left shift (both wrap at 32 bits)
   always_comb begin
      sum1 = acc0 + $signed(bias_t);
      x1_d = sum1;
      if ($signed(shift_t) > 32'sd0) x1_d = sum1 << shift_t;
   end

   // R2: 64-bit product plus rounding nudge; only MIN*MIN can overflow the doubling
   always_comb begin
      ab     = $signed({{32{x1[31]}}, x1}) * $signed({{32{mult1[31]}}, mult1});
      nudge  = ab[63] ? NUDGE_NEG : NUDGE_POS;
      sum2_d = ab + nudge;
      sat2_d = (x1 == INT32_MIN) && (mult1 == INT32_MIN);
   end

   // R3: truncating divide by 2^31, then rounding right shift for negative exponents
   always_comb begin
      biased    = sum2 + (sum2[63] ? 64'sh0000_0000_7fff_ffff : 64'sh0);
      q64       = biased >>> 31;
      hm        = sat2 ? INT32_MAX : q64[31:0];
      neg_shift = -shift2;
      e3        = 5'd0;
      if (shift2[31]) e3 = (neg_shift > 32'd31) ? 5'd31 : neg_shift[4:0];
      r3_d      = rounding_divide_by_pot(hm, e3);
   end

   // R4: offset and clamp; max-with-min first so an inverted range yields act_max
   always_comb begin
      y         = $signed({r3[31], r3}) + $signed({out_offset[31], out_offset});
      lo        = $signed({act_min[31], act_min});
      hi        = $signed({act_max[31], act_max});
      y_lo      = (y < lo) ? lo : y;
      y_clamped = (y_lo > hi) ? hi : y_lo;
   end

   assign unused_bits = ^{q64[63:32], neg_shift[31:5], y_clamped[32:BYTE_SIZE]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v0       <= 1'b0;
         v1       <= 1'b0;
         v2       <= 1'b0;
         v3       <= 1'b0;
         v4       <= 1'b0;
         out_data <= '0;
      end else if (advance) begin
         v0 <= acc_valid;
         v1 <= v0;
         v2 <= v1;
         v3 <= v2;
         v4 <= v3;
         if (v3) out_data <= y_clamped[BYTE_SIZE-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         acc0   <= acc_data;
         x1     <= x1_d;
         mult1  <= mult_t;
         shift1 <= shift_t;
         sum2   <= sum2_d;
         sat2   <= sat2_d;
         shift2 <= shift1;
         r3     <= r3_d;
      end
   end

endmodule

// File: tb/tb_requant_stage.sv
// tb/tb_requant_stage.sv - scoreboard bench for requant_stage against a TFLite-style reference model
module tb_requant_stage;
   import requant_pkg::*;

   localparam int I32MIN = -2147483647 - 1;
   localparam int I32MAX = 2147483647;
   localparam int Q30    = 1073741824;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        acc_valid;
   logic        acc_ready;
   logic [31:0] acc_data;
   logic [6:0]  acc_channel;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        cfg_we;
   logic [2:0]  cfg_sel;
   logic [6:0]  cfg_addr;
   logic [31:0] cfg_data;
   logic        busy;

   always #5 clk = ~clk;

   requant_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .acc_valid   (acc_valid),
      .acc_ready   (acc_ready),
      .acc_data    (acc_data),
      .acc_channel (acc_channel),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .cfg_we      (cfg_we),
      .cfg_sel     (cfg_sel),
      .cfg_addr    (cfg_addr),
      .cfg_data    (cfg_data),
      .busy        (busy)
   );

   int  n_checks = 0;
   int  n_fail   = 0;
   int  n_out    = 0;
   bit  last_taken;
   byte exp_q[$];

   int bias_m [128];
   int mult_m [128];
   int shift_m[128];
   int off_m = 0;
   int min_m = -128;
   int max_m = 127;

   function automatic byte model(input int acc, input int ch);
      int     x, hm, e, r;
      longint ab, nudge, mask, rem, thr, y;
      x = acc + bias_m[ch];
      if (shift_m[ch] > 0) x = x << shift_m[ch];
      ab    = longint'(x) * longint'(mult_m[ch]);
      nudge = (ab >= 0) ? (longint'(1) << 30) : (longint'(1) - (longint'(1) << 30));
      if (x == mult_m[ch] && x == I32MIN) hm = I32MAX;
      else hm = int'((ab + nudge) / (longint'(1) << 31));
      e    = (shift_m[ch] < 0) ? -shift_m[ch] : 0;
      mask = (longint'(1) << e) - 1;
      rem  = longint'(hm) & mask;
      thr  = (mask >> 1) + ((hm < 0) ? 1 : 0);
      r    = (hm >>> e) + ((rem > thr) ? 1 : 0);
      y    = longint'(r) + longint'(off_m);
      if (y < min_m) y = min_m;
      if (y > max_m) y = max_m;
      return byte'(y);
   endfunction

   // One clock: observe handshakes at the falling edge, return just after the rising edge.
   task automatic tick();
      byte e;
      @(negedge clk);
      last_taken = acc_valid && acc_ready && reset_n;
      if (reset_n && out_valid && out_ready) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_extra got=%0d required=none", $signed(out_data));
         end else begin
            e = exp_q.pop_front();
            n_out++;
            if (out_data !== e) begin
               n_fail++;
               $display("FAIL scoreboard_data got=%0d required=%0d", $signed(out_data), e);
            end
         end
      end
      if (last_taken) exp_q.push_back(model(int'(acc_data), int'(acc_channel)));
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [2:0] sel, input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_sel  = sel;
      cfg_addr = addr[6:0];
      cfg_data = data;
      tick();
      cfg_we = 1'b0;
      case (sel)
         CFG_SEL_BIAS:    bias_m[addr]  = data;
         CFG_SEL_MULT:    mult_m[addr]  = data;
         CFG_SEL_SHIFT:   shift_m[addr] = data;
         CFG_SEL_OFFSET:  off_m = data;
         CFG_SEL_ACT_MIN: min_m = data;
         CFG_SEL_ACT_MAX: max_m = data;
         default: ;
      endcase
   endtask

   task automatic set_channel(input int ch, input int b, input int m, input int s);
      cfg_write(CFG_SEL_BIAS, ch, b);
      cfg_write(CFG_SEL_MULT, ch, m);
      cfg_write(CFG_SEL_SHIFT, ch, s);
   endtask

   task automatic send(input int data, input int ch);
      acc_valid   = 1'b1;
      acc_data    = data;
      acc_channel = ch[6:0];
      last_taken  = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (last_taken) break;
      end
      acc_valid = 1'b0;
      if (!last_taken) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout got=not_accepted required=accepted");
      end
   endtask

   task automatic wait_out(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_drain();
      bit done = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (exp_q.size() == 0 && !busy) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain_timeout got=pending(%0d) required=0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; acc_valid = 1'b0; acc_data = '0; acc_channel = '0;
      out_ready = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b required=0", busy); end
      n_checks++;
      if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d required=0", out_data); end
      n_checks++;
      if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_acc_ready got=%b required=1", acc_ready); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_identity();
      set_channel(3, 20, Q30, 0);
      cfg_write(CFG_SEL_OFFSET, 0, -5);
      send(100, 3);
      for (int k = 1; k <= 4; k++) begin
         tick();
         n_checks++;
         if (out_valid !== (k == 4)) begin
            n_fail++;
            $display("FAIL identity_latency cycle=%0d got=%b required=%b", k, out_valid, (k == 4));
         end
      end
      n_checks++;
      if (out_data !== 8'd55) begin n_fail++; $display("FAIL identity_value got=%0d required=55", $signed(out_data)); end
      wait_drain();
      cfg_write(CFG_SEL_OFFSET, 0, 0);
   endtask

   task automatic test_neg_round();
      bit seen;
      set_channel(4, 0, Q30, -2);
      send(-10, 4);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'hff) begin
         n_fail++;
         $display("FAIL neg_round got=%0d seen=%b required=-1", $signed(out_data), seen);
      end
      wait_drain();
   endtask

   task automatic test_saturation();
      bit seen;
      set_channel(5, 0, I32MIN, 0);
      send(I32MIN, 5);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'd127) begin n_fail++; $display("FAIL sat_clamp got=%0d required=127", $signed(out_data)); end
      wait_drain();
      cfg_write(CFG_SEL_ACT_MAX, 0, 50);
      send(I32MIN, 5);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'd50) begin n_fail++; $display("FAIL sat_act_max got=%0d required=50", $signed(out_data)); end
      wait_drain();
      cfg_write(CFG_SEL_ACT_MAX, 0, 127);
      set_channel(6, 0, Q30, 2);
      send(Q30, 6);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'd0) begin n_fail++; $display("FAIL shift_wrap got=%0d required=0", $signed(out_data)); end
      wait_drain();
   endtask

   task automatic test_backpressure();
      int         idx = 0;
      int         n0;
      logic [7:0] held;
      for (int c = 10; c < 17; c++) set_channel(c, c * 3, Q30, 0);
      n0        = n_out;
      out_ready = 1'b0;
      acc_valid = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         acc_data    = idx + 1;
         acc_channel = 7'(10 + idx);
         tick();
         if (last_taken) idx++;
      end
      n_checks++;
      if (idx != 5) begin n_fail++; $display("FAIL bp_accepted got=%0d required=5", idx); end
      n_checks++;
      if (acc_ready !== 1'b0) begin n_fail++; $display("FAIL bp_acc_ready got=%b required=0", acc_ready); end
      held = out_data;
      acc_data    = idx + 1;
      acc_channel = 7'(10 + idx);
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== held) begin
         n_fail++;
         $display("FAIL bp_hold got=%0d/%b required=%0d/1", out_data, out_valid, held);
      end
      out_ready = 1'b1;
      for (int g = 0; g < 50 && idx < 7; g++) begin
         acc_data    = idx + 1;
         acc_channel = 7'(10 + idx);
         tick();
         if (last_taken) idx++;
      end
      acc_valid = 1'b0;
      wait_drain();
      n_checks++;
      if (n_out - n0 != 7) begin n_fail++; $display("FAIL bp_count got=%0d required=7", n_out - n0); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int taken = 0;
      cfg_write(CFG_SEL_OFFSET, 0, 7);
      cfg_write(CFG_SEL_ACT_MIN, 0, -50);
      cfg_write(CFG_SEL_ACT_MAX, 0, 100);
      out_ready = 1'b1;
      acc_valid = 1'b1;
      for (int g = 0; g < 20 && taken < 3; g++) begin
         acc_data    = 1000 + taken;
         acc_channel = 7'd3;
         tick();
         if (last_taken) taken++;
      end
      acc_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got=%b required=1", busy); end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async got=valid%b/busy%b required=0/0", out_valid, busy);
      end
      exp_q.delete();
      off_m = 0; min_m = -128; max_m = 127;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      n_checks++;
      if (acc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_acc_ready got=%b required=1", acc_ready); end
      send(1000, 3);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'd127) begin n_fail++; $display("FAIL rst_default_max got=%0d required=127", $signed(out_data)); end
      wait_drain();
      send(-10, 4);
      wait_out(seen);
      n_checks++;
      if (!seen || out_data !== 8'hff) begin n_fail++; $display("FAIL rst_table_kept got=%0d required=-1", $signed(out_data)); end
      wait_drain();
   endtask

   task automatic test_per_channel();
      int idx = 0;
      int n0;
      int cur;
      for (int c = 0; c < 128; c++)
         set_channel(c, (c - 64) * 100 + int'($urandom_range(0, 99)),
                     int'($urandom_range(32'h4000_0000, 32'h7fff_ffff)),
                     int'($urandom_range(0, 13)) - 12);
      cfg_write(CFG_SEL_OFFSET, 0, 3);
      n0  = n_out;
      cur = int'($urandom_range(0, 8000)) - 4000;
      for (int g = 0; g < 2000 && idx < 128; g++) begin
         out_ready   = 1'($urandom_range(0, 1));
         acc_valid   = 1'b1;
         acc_data    = cur;
         acc_channel = 7'(idx);
         tick();
         if (last_taken) begin
            idx++;
            cur = int'($urandom_range(0, 8000)) - 4000;
         end
      end
      acc_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      n_checks++;
      if (n_out - n0 != 128) begin n_fail++; $display("FAIL per_channel_count got=%0d required=128", n_out - n0); end
      cfg_write(CFG_SEL_OFFSET, 0, 0);
   endtask

   initial begin
      test_reset();
      test_identity();
      test_neg_round();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_per_channel();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1);
   end

endmodule
